traffic_ctrl_param: RTL and testbench

Parametrised main/side-road intersection controller with pedestrian request, all-red clearance, and configurable phase durations. It sits between the side-road vehicle sensor and pedestrian push-button and the lamp drivers and countdown display decoders. It generalises the fixed-timing four-state controller into a six-phase machine whose phase lengths, timer width and side-green extension window are set by parameters.

---
 rtl/traffic_ctrl_param.sv | 158 +++++++++++++++
 tb/tb_traffic_ctrl_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: six-phase main/side-road intersection controller.
// It has a pedestrian request latch, all-red clearance, and a side-green
// window that can end early. All phase lengths are set by parameters.
//
// phase  | meaning
// -------+---------------------------------------------------------
// MAIN_G | main road green, side red; held until minimum met and request
// MAIN_Y | main road yellow, side red
// RED_A  | all-red clearance before side green (skipped if ALL_RED==0)
// SIDE_G | side road green, walk lamp on; may end early if no demand
// SIDE_Y | side road yellow, main red
// RED_B  | all-red clearance before main green (skipped if ALL_RED==0)
module traffic_ctrl_param #(
    parameter int TW         = 5,
    parameter int MAIN_MIN_G = 25,
    parameter int MAIN_Y     = 4,
    parameter int ALL_RED    = 2,
    parameter int SIDE_MIN_G = 5,
    parameter int SIDE_MAX_G = 16,
    parameter int SIDE_Y     = 4
) (
    input  logic          CLK,
    input  logic          RET,
    input  logic          C,
    input  logic          PED,
    output logic          MG,
    output logic          MY,
    output logic          MRR,
    output logic          CG,
    output logic          CY,
    output logic          CRR,
    output logic          WALK,
    output logic          PED_PEND,
    output logic [TW-1:0] T1,
    output logic [2:0]    PHASE
);

    typedef enum logic [2:0] {
        S_MAIN_G = 3'd0,
        S_MAIN_Y = 3'd1,
        S_RED_A  = 3'd2,
        S_SIDE_G = 3'd3,
        S_SIDE_Y = 3'd4,
        S_RED_B  = 3'd5
    } phase_t;

    // Counter load values are the duration minus one. The counter runs down to zero.
    localparam logic [TW-1:0] LD_MAIN_G = TW'(MAIN_MIN_G - 1);
    localparam logic [TW-1:0] LD_MAIN_Y = TW'(MAIN_Y - 1);
    localparam logic [TW-1:0] LD_RED    = TW'((ALL_RED > 0) ? ALL_RED - 1 : 0);
    localparam logic [TW-1:0] LD_SIDE_G = TW'(SIDE_MAX_G - 1);
    localparam logic [TW-1:0] LD_SIDE_Y = TW'(SIDE_Y - 1);
    // Side green may end early once at least SIDE_MIN_G cycles have been shown.
    localparam logic [TW-1:0] EXT_WIN   = TW'(SIDE_MAX_G - SIDE_MIN_G);

    phase_t        phase, nxt_phase;
    logic [TW-1:0] nxt_t1, t1_dec;
    logic          served, nxt_served, nxt_pend;

    assign PHASE = phase;

    // Next-phase decision, counter reload/decrement and pedestrian latch update
    always_comb begin
        t1_dec     = (T1 == '0) ? '0 : T1 - 1'b1;
        nxt_phase  = phase;
        nxt_t1     = t1_dec;
        nxt_served = served;
        nxt_pend   = PED_PEND | (PED & (phase != S_SIDE_G));
        case (phase)
            S_MAIN_G: begin
                if (T1 == '0 && (C || PED_PEND)) begin
                    nxt_phase = S_MAIN_Y;
                    nxt_t1    = LD_MAIN_Y;
                end
            end
            S_MAIN_Y: begin
                if (T1 == '0) begin
                    if (ALL_RED == 0) begin
                        nxt_phase  = S_SIDE_G;
                        nxt_t1     = LD_SIDE_G;
                        nxt_served = nxt_pend;
                        nxt_pend   = 1'b0;
                    end else begin
                        nxt_phase = S_RED_A;
                        nxt_t1    = LD_RED;
                    end
                end
            end
            S_RED_A: begin
                if (T1 == '0) begin
                    nxt_phase  = S_SIDE_G;
                    nxt_t1     = LD_SIDE_G;
                    nxt_served = nxt_pend;
                    nxt_pend   = 1'b0;
                end
            end
            S_SIDE_G: begin
                if (T1 == '0 || (!C && !served && T1 <= EXT_WIN)) begin
                    nxt_phase = S_SIDE_Y;
                    nxt_t1    = LD_SIDE_Y;
                end
            end
            S_SIDE_Y: begin
                if (T1 == '0) begin
                    if (ALL_RED == 0) begin
                        nxt_phase = S_MAIN_G;
                        nxt_t1    = LD_MAIN_G;
                    end else begin
                        nxt_phase = S_RED_B;
                        nxt_t1    = LD_RED;
                    end
                end
            end
            S_RED_B: begin
                if (T1 == '0) begin
                    nxt_phase = S_MAIN_G;
                    nxt_t1    = LD_MAIN_G;
                end
            end
            default: begin
                nxt_phase  = S_MAIN_G;
                nxt_t1     = LD_MAIN_G;
                nxt_served = 1'b0;
                nxt_pend   = 1'b0;
            end
        endcase
    end

    // Phase/counter registers. Lamps are decoded from the next phase so they stay registered.
    always_ff @(posedge CLK) begin
        if (!RET) begin
            phase    <= S_MAIN_G;
            T1       <= LD_MAIN_G;
            PED_PEND <= 1'b0;
            served   <= 1'b0;
            MG       <= 1'b1;
            MY       <= 1'b0;
            MRR      <= 1'b0;
            CG       <= 1'b0;
            CY       <= 1'b0;
            CRR      <= 1'b1;
            WALK     <= 1'b0;
        end else begin
            phase    <= nxt_phase;
            T1       <= nxt_t1;
            PED_PEND <= nxt_pend;
            served   <= nxt_served;
            MG       <= (nxt_phase == S_MAIN_G);
            MY       <= (nxt_phase == S_MAIN_Y);
            MRR      <= (nxt_phase inside {S_RED_A, S_SIDE_G, S_SIDE_Y, S_RED_B});
            CG       <= (nxt_phase == S_SIDE_G);
            CY       <= (nxt_phase == S_SIDE_Y);
            CRR      <= (nxt_phase inside {S_MAIN_G, S_MAIN_Y, S_RED_A, S_RED_B});
            WALK     <= (nxt_phase == S_SIDE_G);
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param. It runs a default build and a build with ALL_RED=0.
module tb_traffic_ctrl_param;

    logic       CLK = 1'b0;
    logic       RET = 1'b0;
    logic       C   = 1'b0;
    logic       PED = 1'b0;
    logic       MG, MY, MRR, CG, CY, CRR, WALK, PED_PEND;
    logic [4:0] T1;
    logic [2:0] PHASE;

    logic       c2   = 1'b0;
    logic       ped2 = 1'b0;
    logic       mg2, my2, mrr2, cg2, cy2, crr2, walk2, pend2;
    logic [4:0] t1_2;
    logic [2:0] phase2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    traffic_ctrl_param dut (
        .CLK(CLK), .RET(RET), .C(C), .PED(PED),
        .MG(MG), .MY(MY), .MRR(MRR), .CG(CG), .CY(CY), .CRR(CRR),
        .WALK(WALK), .PED_PEND(PED_PEND), .T1(T1), .PHASE(PHASE)
    );

    traffic_ctrl_param #(.ALL_RED(0)) dut_nr (
        .CLK(CLK), .RET(RET), .C(c2), .PED(ped2),
        .MG(mg2), .MY(my2), .MRR(mrr2), .CG(cg2), .CY(cy2), .CRR(crr2),
        .WALK(walk2), .PED_PEND(pend2), .T1(t1_2), .PHASE(phase2)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Lamp order: {MG, MY, MRR, CG, CY, CRR, WALK}
    function automatic logic [6:0] exp_lamps(input int p);
        case (p)
            0:       return 7'b1000010;
            1:       return 7'b0100010;
            2, 5:    return 7'b0010010;
            3:       return 7'b0011001;
            4:       return 7'b0010100;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [14:0] obs1();
        return {PHASE, T1, MG, MY, MRR, CG, CY, CRR, WALK};
    endfunction

    function automatic logic [14:0] obs2();
        return {phase2, t1_2, mg2, my2, mrr2, cg2, cy2, crr2, walk2};
    endfunction

    task automatic step();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RET = 1'b0;
        @(negedge CLK);
        RET = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        C = 1'b0; PED = 1'b0; c2 = 1'b0;
        do_reset();
        checks++;
        if ({obs1(), PED_PEND} !== {3'd0, 5'd24, 7'b1000010, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", {obs1(), PED_PEND}, {3'd0, 5'd24, 7'b1000010, 1'b0});
        end
        checks++;
        if ({obs2(), pend2} !== {3'd0, 5'd24, 7'b1000010, 1'b0}) begin
            errors++;
            $display("FAIL reset_state_nored got %h exp %h", {obs2(), pend2}, {3'd0, 5'd24, 7'b1000010, 1'b0});
        end
    endtask

    task automatic test_c_held();
        int d[6] = '{25, 4, 2, 16, 4, 2};
        int ph = 0;
        int rem = 24;
        logic [14:0] exp;
        C = 1'b1; PED = 1'b0;
        do_reset();
        for (int k = 0; k < 106; k++) begin
            exp = {3'(ph), 5'(rem), exp_lamps(ph)};
            checks++;
            if (obs1() !== exp) begin
                errors++;
                $display("FAIL c_held cycle %0d got %h exp %h", cyc, obs1(), exp);
            end
            if (rem == 0) begin
                ph = (ph + 1) % 6;
                rem = d[ph] - 1;
            end else begin
                rem--;
            end
            step();
        end
    endtask

    task automatic test_idle();
        logic [14:0] exp;
        C = 1'b0; PED = 1'b0;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            exp = {3'd0, 5'((k < 24) ? 24 - k : 0), 7'b1000010};
            checks++;
            if (obs1() !== exp) begin
                errors++;
                $display("FAIL idle cycle %0d got %h exp %h", cyc, obs1(), exp);
            end
            step();
        end
    endtask

    task automatic test_early_exit();
        int n = 0;
        C = 1'b1; PED = 1'b0;
        do_reset();
        while (cyc < 31) step();
        checks++;
        if ({PHASE, T1, CG} !== {3'd3, 5'd15, 1'b1}) begin
            errors++;
            $display("FAIL early_entry got %h exp %h", {PHASE, T1, CG}, {3'd3, 5'd15, 1'b1});
        end
        for (int i = 0; i < 20; i++) begin
            if (!CG) break;
            n++;
            if (cyc == 32) C = 1'b0;
            step();
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL early_green_len got %0d exp %0d", n, 5);
        end
        checks++;
        if ({cyc[7:0], obs1()} !== {8'd36, 3'd4, 5'd3, 7'b0010100}) begin
            errors++;
            $display("FAIL early_to_yellow got %h exp %h", {cyc[7:0], obs1()}, {8'd36, 3'd4, 5'd3, 7'b0010100});
        end
    endtask

    task automatic test_ped();
        int n = 0;
        C = 1'b0; PED = 1'b0;
        do_reset();
        while (cyc < 3) step();
        checks++;
        if (PED_PEND !== 1'b0) begin
            errors++;
            $display("FAIL ped_pre got %b exp %b", PED_PEND, 1'b0);
        end
        PED = 1'b1;
        step();
        PED = 1'b0;
        checks++;
        if (PED_PEND !== 1'b1) begin
            errors++;
            $display("FAIL ped_latch got %b exp %b", PED_PEND, 1'b1);
        end
        while (cyc < 24) step();
        checks++;
        if ({PHASE, T1, MG} !== {3'd0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL ped_main_end got %h exp %h", {PHASE, T1, MG}, {3'd0, 5'd0, 1'b1});
        end
        step();
        checks++;
        if ({PHASE, T1, MY} !== {3'd1, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL ped_yellow got %h exp %h", {PHASE, T1, MY}, {3'd1, 5'd3, 1'b1});
        end
        while (cyc < 31) step();
        checks++;
        if ({PHASE, T1, WALK, CG, PED_PEND} !== {3'd3, 5'd15, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ped_side_entry got %h exp %h", {PHASE, T1, WALK, CG, PED_PEND},
                     {3'd3, 5'd15, 1'b1, 1'b1, 1'b0});
        end
        for (int i = 0; i < 30; i++) begin
            if (!WALK) break;
            n++;
            if (cyc == 35) PED = 1'b1;
            if (cyc == 36) begin
                PED = 1'b0;
                checks++;
                if (PED_PEND !== 1'b0) begin
                    errors++;
                    $display("FAIL ped_in_side_ignored got %b exp %b", PED_PEND, 1'b0);
                end
            end
            step();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL ped_walk_len got %0d exp %0d", n, 16);
        end
        checks++;
        if ({cyc[7:0], obs1()} !== {8'd47, 3'd4, 5'd3, 7'b0010100}) begin
            errors++;
            $display("FAIL ped_side_yellow got %h exp %h", {cyc[7:0], obs1()}, {8'd47, 3'd4, 5'd3, 7'b0010100});
        end
    endtask

    task automatic test_reset_mid();
        C = 1'b1; PED = 1'b0;
        do_reset();
        while (cyc < 47) step();
        checks++;
        if ({PHASE, T1, CY} !== {3'd4, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL mid_side_yellow got %h exp %h", {PHASE, T1, CY}, {3'd4, 5'd3, 1'b1});
        end
        PED = 1'b1;
        step();
        PED = 1'b0;
        checks++;
        if ({PHASE, T1, PED_PEND} !== {3'd4, 5'd2, 1'b1}) begin
            errors++;
            $display("FAIL mid_pend_set got %h exp %h", {PHASE, T1, PED_PEND}, {3'd4, 5'd2, 1'b1});
        end
        RET = 1'b0;
        step();
        RET = 1'b1;
        checks++;
        if ({obs1(), PED_PEND} !== {3'd0, 5'd24, 7'b1000010, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", {obs1(), PED_PEND}, {3'd0, 5'd24, 7'b1000010, 1'b0});
        end
        step();
        checks++;
        if ({PHASE, T1} !== {3'd0, 5'd23}) begin
            errors++;
            $display("FAIL mid_after_reset got %h exp %h", {PHASE, T1}, {3'd0, 5'd23});
        end
    endtask

    task automatic test_all_red_zero();
        int d[6] = '{25, 4, 0, 16, 4, 0};
        int ph = 0;
        int rem = 24;
        logic [14:0] exp;
        c2 = 1'b1; C = 1'b1;
        do_reset();
        for (int k = 0; k < 98; k++) begin
            exp = {3'(ph), 5'(rem), exp_lamps(ph)};
            checks++;
            if (obs2() !== exp) begin
                errors++;
                $display("FAIL nored cycle %0d got %h exp %h", cyc, obs2(), exp);
            end
            checks++;
            if ((mrr2 & crr2) !== 1'b0) begin
                errors++;
                $display("FAIL nored_all_red cycle %0d got %b exp %b", cyc, mrr2 & crr2, 1'b0);
            end
            if (rem == 0) begin
                ph = (ph + 1) % 6;
                while (d[ph] == 0) ph = (ph + 1) % 6;
                rem = d[ph] - 1;
            end else begin
                rem--;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_c_held();
        test_idle();
        test_early_exit();
        test_ped();
        test_reset_mid();
        test_all_red_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
